// File: rtl/wm_cycle_controller.sv
// Washing-machine cycle sequencer: IDLE/READY/FILL/HEAT/WASH/RINSE/SPIN/FAULT
// with per-phase timeouts, configurable rinse passes, cold-wash bypass of HEAT,
// lid supervision, a latched fault code and a timed fault hold.
module wm_cycle_controller #(
  parameter int TIMER_WIDTH  = 16,
  parameter int FILL_TIMEOUT = 1000,
  parameter int HEAT_TIMEOUT = 2000,
  parameter int NUM_RINSES   = 2,
  parameter int FAULT_HOLD   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sig_Coin,
  input  logic       sig_Cancel,
  input  logic       sig_Cold_Wash,
  input  logic       sig_Lid_Closed,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Wash_Completed,
  input  logic       sig_Rinse_Completed,
  input  logic       sig_Spin_Completed,
  input  logic       sig_Out_Of_Balance,
  input  logic       sig_Motor_Failure,
  output logic       start,
  output logic       ready,
  output logic       fill_Water_Operation,
  output logic       heat_Water_Operation,
  output logic       wash_Operation,
  output logic       rinse_Operation,
  output logic       spin_Operation,
  output logic       fault,
  output logic       water_Intake,
  output logic       coin_Return,
  output logic       fault_Cleared,
  output logic       cycle_Done,
  output logic [2:0] fault_Code,
  output logic [2:0] rinse_Count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_FILL  = 3'd2,
    S_HEAT  = 3'd3,
    S_WASH  = 3'd4,
    S_RINSE = 3'd5,
    S_SPIN  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] FILL_LAST  = TIMER_WIDTH'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] HEAT_LAST  = TIMER_WIDTH'(HEAT_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] HOLD_LAST  = TIMER_WIDTH'(FAULT_HOLD - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);
  localparam logic [2:0]             RINSE_LAST = 3'(NUM_RINSES);

  localparam logic [2:0] CODE_FILL_TO  = 3'd1;
  localparam logic [2:0] CODE_HEAT_TO  = 3'd2;
  localparam logic [2:0] CODE_BALANCE  = 3'd3;
  localparam logic [2:0] CODE_MOTOR    = 3'd4;
  localparam logic [2:0] CODE_LID_OPEN = 3'd5;

  state_t                 cur, nxt;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   cold, cold_nxt;
  logic [2:0]             code_nxt, rinse_nxt, rinse_inc;
  logic                   coin_ret_nxt, clr_nxt, done_nxt;
  logic                   lid_fault;

  // Next-state, fault code, rinse count and pulse requests
  always_comb begin
    nxt          = cur;
    code_nxt     = fault_Code;
    rinse_nxt    = rinse_Count;
    cold_nxt     = cold;
    coin_ret_nxt = 1'b0;
    clr_nxt      = 1'b0;
    done_nxt     = 1'b0;
    rinse_inc    = rinse_Count + 3'd1;
    // Lid opening during any active phase overrides everything else
    lid_fault    = (cur == S_FILL || cur == S_HEAT || cur == S_WASH ||
                    cur == S_RINSE || cur == S_SPIN) && !sig_Lid_Closed;
    if (lid_fault) begin
      nxt      = S_FAULT;
      code_nxt = CODE_LID_OPEN;
    end else begin
      case (cur)
        S_IDLE: if (sig_Coin) nxt = S_READY;
        S_READY: begin
          if (sig_Cancel) begin
            nxt          = S_IDLE;
            coin_ret_nxt = 1'b1;
          end else if (sig_Lid_Closed) begin
            nxt       = S_FILL;
            cold_nxt  = sig_Cold_Wash;
            rinse_nxt = 3'd0;
          end
        end
        S_FILL: begin
          if (sig_Full) nxt = cold ? S_WASH : S_HEAT;
          else if (timer == FILL_LAST) begin
            nxt      = S_FAULT;
            code_nxt = CODE_FILL_TO;
          end
        end
        S_HEAT: begin
          if (sig_Temperature) nxt = S_WASH;
          else if (timer == HEAT_LAST) begin
            nxt      = S_FAULT;
            code_nxt = CODE_HEAT_TO;
          end
        end
        S_WASH: begin
          if (sig_Wash_Completed) nxt = S_RINSE;
          else if (sig_Out_Of_Balance) begin
            nxt      = S_FAULT;
            code_nxt = CODE_BALANCE;
          end
        end
        S_RINSE: begin
          if (sig_Rinse_Completed) begin
            rinse_nxt = rinse_inc;
            if (rinse_inc == RINSE_LAST) nxt = S_SPIN;
          end else if (sig_Motor_Failure) begin
            nxt      = S_FAULT;
            code_nxt = CODE_MOTOR;
          end
        end
        S_SPIN: begin
          if (sig_Spin_Completed) begin
            nxt      = S_READY;
            done_nxt = 1'b1;
          end else if (sig_Motor_Failure) begin
            nxt      = S_FAULT;
            code_nxt = CODE_MOTOR;
          end else if (sig_Out_Of_Balance) begin
            nxt      = S_FAULT;
            code_nxt = CODE_BALANCE;
          end
        end
        S_FAULT: begin
          if (timer == HOLD_LAST) begin
            nxt     = S_READY;
            clr_nxt = 1'b1;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State, latched context and registered pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur           <= S_IDLE;
      cold          <= 1'b0;
      fault_Code    <= 3'd0;
      rinse_Count   <= 3'd0;
      coin_Return   <= 1'b0;
      fault_Cleared <= 1'b0;
      cycle_Done    <= 1'b0;
    end else begin
      cur           <= nxt;
      cold          <= cold_nxt;
      fault_Code    <= code_nxt;
      rinse_Count   <= rinse_nxt;
      coin_Return   <= coin_ret_nxt;
      fault_Cleared <= clr_nxt;
      cycle_Done    <= done_nxt;
    end
  end

  // Phase timer: restarts on every state change, saturates while held
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               timer <= '0;
    else if (nxt != cur)        timer <= '0;
    else if (timer != '1)       timer <= timer + TIMER_ONE;
  end

  assign state                = cur;
  assign start                = (cur == S_IDLE);
  assign ready                = (cur == S_READY);
  assign fill_Water_Operation = (cur == S_FILL);
  assign heat_Water_Operation = (cur == S_HEAT);
  assign wash_Operation       = (cur == S_WASH);
  assign rinse_Operation      = (cur == S_RINSE);
  assign spin_Operation       = (cur == S_SPIN);
  assign fault                = (cur == S_FAULT);
  assign water_Intake         = (cur == S_FILL) || (cur == S_RINSE);

endmodule

// File: doc/wm_cycle_controller.md
Name: wm_cycle_controller

Overview:
- Parametrised washing-machine cycle sequencer.
- Successor to the fixed single-rinse controller: adds internal per-phase timeout counters, a configurable rinse count, a cold-wash mode that skips heating, lid-open supervision, latched fault codes, and a timed fault hold.
- Sits between the coin/lid front panel and the valve, heater and motor drivers.

Parameters:
- TIMER_WIDTH, 16, width of the phase timeout counter.
- FILL_TIMEOUT, 1000, cycles allowed in FILL before a fill-timeout fault.
- HEAT_TIMEOUT, 2000, cycles allowed in HEAT before a heat-timeout fault.
- NUM_RINSES, 2, rinse passes per cycle. Legal range 1..7.
- FAULT_HOLD, 8, cycles spent in FAULT before returning to READY. Must be at least 1.

Ports:
- clock  input  1  system clock; all state changes occur on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sig_Coin  input  1  coin inserted (level).
- sig_Cancel  input  1  user cancel.
- sig_Cold_Wash  input  1  mode select, sampled on the READY->FILL transition. 1 = skip HEAT.
- sig_Lid_Closed  input  1  lid closed.
- sig_Full  input  1  drum full.
- sig_Temperature  input  1  target temperature reached.
- sig_Wash_Completed  input  1  wash phase done.
- sig_Rinse_Completed  input  1  one rinse pass done (single-cycle pulse expected).
- sig_Spin_Completed  input  1  spin done.
- sig_Out_Of_Balance  input  1  drum imbalance.
- sig_Motor_Failure  input  1  motor fault.
- start, ready, fill_Water_Operation, heat_Water_Operation, wash_Operation, rinse_Operation, spin_Operation, fault  output  1 each  one-hot state decodes.
- water_Intake  output  1  high in FILL or RINSE.
- coin_Return  output  1  one-cycle pulse on cancel from READY.
- fault_Cleared  output  1  one-cycle pulse on the FAULT->READY exit.
- cycle_Done  output  1  one-cycle pulse on the SPIN->READY exit.
- fault_Code  output  3  last fault cause, held.
- rinse_Count  output  3  completed rinse passes in the current cycle.
- state  output  3  encoded state.

Behaviour:
- State encoding: IDLE=0, READY=1, FILL=2, HEAT=3, WASH=4, RINSE=5, SPIN=6, FAULT=7. `state` is registered.
- Decode outputs are combinational from `state`. Pulses are registered and assert in the cycle the new state is first visible.
- Reset (asynchronous, reset_n=0):
  - state=IDLE, timer=0, rinse_Count=0, fault_Code=0, cold flag=0, all pulses 0.
  - Hence start=1 and every other decode is 0.
  - Reset mid-operation aborts immediately; no pulse is emitted.
- Transitions, evaluated each rising edge, priority top-down within a state:
  - IDLE: sig_Coin -> READY.
  - READY:
    - sig_Cancel -> IDLE with a coin_Return pulse. Cancel wins over lid.
    - Otherwise sig_Lid_Closed -> FILL; latch cold flag = sig_Cold_Wash; clear rinse_Count.
  - FILL:
    - sig_Full -> HEAT, or -> WASH if the cold flag is set.
    - Else timer == FILL_TIMEOUT-1 -> FAULT, code 1.
  - HEAT:
    - sig_Temperature -> WASH.
    - Else timer == HEAT_TIMEOUT-1 -> FAULT, code 2.
  - WASH: sig_Wash_Completed -> RINSE; else sig_Out_Of_Balance -> FAULT, code 3.
  - RINSE:
    - sig_Rinse_Completed: rinse_Count increments.
    - If the new count == NUM_RINSES -> SPIN; otherwise stay in RINSE.
    - Else sig_Motor_Failure -> FAULT, code 4.
  - SPIN:
    - sig_Spin_Completed -> READY with a cycle_Done pulse.
    - Else sig_Motor_Failure -> FAULT, code 4.
    - Else sig_Out_Of_Balance -> FAULT, code 3.
  - FAULT: timer == FAULT_HOLD-1 -> READY with a fault_Cleared pulse. No input affects FAULT.
- Lid supervision:
  - In FILL, HEAT, WASH, RINSE and SPIN, sig_Lid_Closed=0 -> FAULT, code 5.
  - It has the highest priority, over both completion and the other faults.
- Completion vs fault: in the same cycle, completion wins, except for lid-open.
- Timer:
  - Clears to 0 on every state change; increments each cycle while the state is held.
  - Saturates at all-ones.
  - A FILL or HEAT timeout fires exactly FILL_TIMEOUT or HEAT_TIMEOUT cycles after entry.
- fault_Code:
  - Written only on entry to FAULT.
  - Held through READY and later cycles until the next fault or reset.
- rinse_Count: holds its value after SPIN until the next READY->FILL transition.
- Wrap and width: rinse_Count never exceeds NUM_RINSES; parameters wider than TIMER_WIDTH are illegal.

Test Plan:
1. Hot cycle, NUM_RINSES=2: coin, lid, Full@+5, Temperature@+10, Wash, Rinse pulse x2, Spin.
   - Required: state sequence 0,1,2,3,4,5,5,6,1.
   - Required: rinse_Count goes 1 then 2; single cycle_Done pulse.
2. Cold wash: sig_Cold_Wash=1 at lid close, Full.
   - Required: FILL->WASH directly; heat_Water_Operation never asserts.
3. Fill timeout, FILL_TIMEOUT=1000, Full held 0.
   - Required: FAULT entered exactly 1000 cycles after FILL entry; fault_Code=1.
   - Required: 8 cycles later READY with a fault_Cleared pulse.
4. Simultaneous events in RINSE:
   - Rinse_Completed with Motor_Failure on the final pass -> SPIN.
   - Lid_Closed=0 with Spin_Completed in SPIN -> FAULT, code 5.
5. READY with Cancel and Lid_Closed both high -> IDLE and a coin_Return pulse; FILL not entered.
6. reset_n low for 1 cycle mid-WASH, asynchronous to clock.
   - Required: state=0 immediately; fault_Code=0, rinse_Count=0; no pulses.
